rc4_nibble_keystream: RTL and testbench
=======================================

// Module: rc4_nibble_keystream
// PURPOSE
//  Downstream consumer of the SPECK hash stage: reads the 64-bit hash out of the final-value
//  memory as KEY_LEN 4-bit nibbles and uses them as the key of an RC4-style cipher.
//  Runs key scheduling (KSA) over a 2^W-entry S-box, then streams W-bit keystream words
//  to the encrypt/decrypt path of the processor under a valid/ready handshake.
// PARAMETERS
//  W        4   S-box index/value width; S-box has N = 2^W entries
//  KEY_LEN  16  key nibbles accepted per load (16 x 4 = 64-bit hash)
//  DROP_N   16  keystream words discarded after KSA (only with RC4_DROP_EN)
// PORTS
//  clk       in   1  single clock, rising edge
//  reset     in   1  asynchronous, active-low reset
//  rekey     in   1  pulse: abort the current key/stream, return to IDLE
//  key_valid in   1  key_nib is valid
//  key_nib   in   4  key nibble, first nibble = key index 0
//  key_ready out  1  block accepts a key nibble this cycle
//  busy      out  1  high in INIT, KSA, DROP
//  ks_valid  out  1  ks_word holds an unconsumed keystream word
//  ks_word   out  W  keystream word
//  ks_ready  in   1  downstream accepts ks_word
// BEHAVIOUR
//  Reset: state=IDLE, i=j=0, key regs=0, S[k]=k, key_ready=0, busy=0, ks_valid=0, ks_word=0.
//  States: IDLE -> LOAD -> INIT -> KSA -> [DROP] -> GEN.
//  IDLE: key_ready=0 for exactly one cycle after reset/rekey; then -> LOAD.
//  LOAD: key_ready=1; each key_valid&key_ready stores nibble at index cnt, cnt++;
//   after nibble KEY_LEN-1 accepted -> INIT (key_ready drops the next cycle).
//  INIT (1 cycle): S[k]=k for all k, i=0, j=0 -> KSA.
//  KSA (N cycles, one per edge): j=j+S[i]+K[i mod KEY_LEN] mod N; swap S[i],S[j]; i++;
//   after i=N-1 -> i=0, j=0, then DROP (macro set) or GEN.
//  Step function (DROP and GEN): i'=i+1, j'=j+S[i'], swap S[i'],S[j'],
//   word = S[(S[i']+S[j']) mod N] using post-swap values; all sums mod N (W-bit wrap).
//  GEN: step fires when !ks_valid or (ks_valid & ks_ready); result registered into
//   ks_word, ks_valid=1 next edge. Full throughput: one word per cycle while ks_ready=1.
//  ks_valid & !ks_ready: ks_word, S, i, j held stable until accepted (no drops, no dupes).
//  Latency: ks_valid rises on the (N+2)th edge after the edge accepting the last key nibble.
//  key_valid outside LOAD ignored. rekey in any state: next edge -> IDLE, ks_valid=0,
//   cnt=0, i=j=0; rekey wins over a simultaneous key_valid or handshake.
//  Reset mid-operation: immediate return to reset values; no partial key retained.
// CONFIGURATION
//  RC4_DROP_EN defined: after KSA, DROP state performs DROP_N steps (one per edge,
//   ks_valid=0, busy=1), then GEN; first ks_valid delayed by DROP_N cycles.
//  RC4_DROP_EN undefined: no DROP state; KSA goes straight to GEN; DROP_N unused.
// TESTING
//  Reset asserted mid-KSA -> all outputs at reset values same cycle; key_ready=1 two edges after release.
//  Load 16 nibbles 0x0..0xF back-to-back -> key_ready low after 16th; ks_valid at edge 18 (34 with RC4_DROP_EN).
//  Key = hash 0x0123456789ABCDEF, ks_ready=1 for 64 cycles -> 64 words match bench RC4 model, S stays a permutation.
//  Same key, ks_ready toggled 1/0 randomly -> accepted sequence identical to previous scenario.
//  key_valid gapped (every 3rd cycle) -> only handshaked nibbles stored; stream equals gap-free load.
//  rekey during GEN with key_valid=1 -> ks_valid=0 next edge, IDLE, reload of new key gives fresh stream.

Source files
------------

// File: rtl/rc4_nibble_keystream.sv
// RC4-style keystream generator keyed by KEY_LEN 4-bit hash nibbles over a 2^W-entry S-box.
// Optional post-KSA discard of DROP_N words is enabled by defining RC4_DROP_EN.
module rc4_nibble_keystream #(
  parameter int unsigned W       = 4,
  parameter int unsigned KEY_LEN = 16,
  parameter int unsigned DROP_N  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rekey,
  input  logic         key_valid,
  input  logic [3:0]   key_nib,
  output logic         key_ready,
  output logic         busy,
  output logic         ks_valid,
  output logic [W-1:0] ks_word,
  input  logic         ks_ready
);

  localparam int unsigned N   = 1 << W;
  localparam int unsigned KCW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int unsigned DCW = (DROP_N > 1) ? $clog2(DROP_N) : 1;
`ifdef RC4_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, INIT, KSA, DROP, GEN} state_t;

  state_t           state_q, state_d;
  logic [KCW-1:0]   cnt_q, cnt_d;
  logic [DCW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [W-1:0]     i_q, i_d, j_q, j_d;
  logic [3:0]       key_q [KEY_LEN];
  logic [3:0]       key_d [KEY_LEN];
  logic [W-1:0]     s_q [N];
  logic [W-1:0]     s_d [N];
  logic             key_ready_q, key_ready_d;
  logic             busy_q, busy_d;
  logic             ks_valid_q, ks_valid_d;
  logic [W-1:0]     ks_word_q, ks_word_d;

  logic [W-1:0]     i1, j1, si, sj, t, word;
  logic [KCW-1:0]   kidx;
  logic [W-1:0]     key_w, kj;

  always_comb begin
    // Step outputs are formed from pre-swap reads; the post-swap lookup at t
    // is patched for the two swapped slots instead of chaining a second read.
    i1   = i_q + W'(1);
    si   = s_q[i1];
    j1   = j_q + si;
    sj   = s_q[j1];
    t    = si + sj;
    word = (t == i1) ? sj : ((t == j1) ? si : s_q[t]);

    kidx  = KCW'(32'(i_q) % KEY_LEN);
    key_w = W'(key_q[kidx]);
    kj    = j_q + s_q[i_q] + key_w;

    state_d    = state_q;
    cnt_d      = cnt_q;
    drop_cnt_d = drop_cnt_q;
    i_d        = i_q;
    j_d        = j_q;
    key_d      = key_q;
    s_d        = s_q;
    ks_valid_d = ks_valid_q;
    ks_word_d  = ks_word_q;

    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (key_valid && key_ready_q) begin
          key_d[cnt_q] = key_nib;
          if (cnt_q == KCW'(KEY_LEN - 1)) begin
            cnt_d   = '0;
            state_d = INIT;
          end else begin
            cnt_d = cnt_q + KCW'(1);
          end
        end
      end
      INIT: begin
        for (int unsigned k = 0; k < N; k++) s_d[k] = W'(k);
        i_d     = '0;
        j_d     = '0;
        state_d = KSA;
      end
      KSA: begin
        s_d[i_q] = s_q[kj];
        s_d[kj]  = s_q[i_q];
        j_d      = kj;
        i_d      = i_q + W'(1);
        if (i_q == W'(N - 1)) begin
          i_d        = '0;
          j_d        = '0;
          drop_cnt_d = '0;
          state_d    = DROP_EN ? DROP : GEN;
        end
      end
      DROP: begin
        s_d[i1] = sj;
        s_d[j1] = si;
        i_d     = i1;
        j_d     = j1;
        if (drop_cnt_q == DCW'(DROP_N - 1)) state_d = GEN;
        else drop_cnt_d = drop_cnt_q + DCW'(1);
      end
      GEN: begin
        if (!ks_valid_q || ks_ready) begin
          s_d[i1]    = sj;
          s_d[j1]    = si;
          i_d        = i1;
          j_d        = j1;
          ks_word_d  = word;
          ks_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rekey) begin
      state_d    = IDLE;
      cnt_d      = '0;
      i_d        = '0;
      j_d        = '0;
      s_d        = s_q;
      ks_valid_d = 1'b0;
      ks_word_d  = ks_word_q;
    end

    key_ready_d = (state_q == LOAD) && (state_d == LOAD);
    busy_d      = state_d inside {INIT, KSA, DROP};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drop_cnt_q  <= '0;
      i_q         <= '0;
      j_q         <= '0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      ks_valid_q  <= 1'b0;
      ks_word_q   <= '0;
      for (int unsigned k = 0; k < KEY_LEN; k++) key_q[k] <= '0;
      for (int unsigned k = 0; k < N; k++) s_q[k] <= W'(k);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      i_q         <= i_d;
      j_q         <= j_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
      ks_valid_q  <= ks_valid_d;
      ks_word_q   <= ks_word_d;
      key_q       <= key_d;
      s_q         <= s_d;
    end
  end

  assign key_ready = key_ready_q;
  assign busy      = busy_q;
  assign ks_valid  = ks_valid_q;
  assign ks_word   = ks_word_q;

endmodule

// File: tb/tb_rc4_nibble_keystream.sv
// Directed/randomized bench for rc4_nibble_keystream against a plain RC4 reference model.
module tb_rc4_nibble_keystream;

  localparam int N  = 16;
  localparam int KL = 16;
`ifdef RC4_DROP_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 18;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rekey, key_valid, ks_ready;
  logic [3:0] key_nib;
  logic       key_ready, busy, ks_valid;
  logic [3:0] ks_word;

  always #5 clk = ~clk;

  rc4_nibble_keystream #(.W(4), .KEY_LEN(16), .DROP_N(16)) dut (
    .clk(clk), .reset(reset), .rekey(rekey), .key_valid(key_valid), .key_nib(key_nib),
    .key_ready(key_ready), .busy(busy), .ks_valid(ks_valid), .ks_word(ks_word),
    .ks_ready(ks_ready)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int key_arr [KL];
  int ms [N];
  int mi, mj;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Textbook RC4 over a 16-entry S-box with the 16-nibble key.
  function automatic int model_next();
    int tmp;
    mi = (mi + 1) % N;
    mj = (mj + ms[mi]) % N;
    tmp = ms[mi]; ms[mi] = ms[mj]; ms[mj] = tmp;
    return ms[(ms[mi] + ms[mj]) % N];
  endfunction

  task automatic model_ksa();
    int j, tmp, d;
    for (int s = 0; s < N; s++) ms[s] = s;
    j = 0;
    for (int i = 0; i < N; i++) begin
      j = (j + ms[i] + key_arr[i % KL]) % N;
      tmp = ms[i]; ms[i] = ms[j]; ms[j] = tmp;
    end
    mi = 0;
    mj = 0;
`ifdef RC4_DROP_EN
    for (int k = 0; k < 16; k++) d = model_next();
`endif
  endtask

  task automatic load_key(input int gap);
    int idx, cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    while (idx < KL && cyc < 400) begin
      key_valid = (gap == 0) || (cyc % gap == 0);
      key_nib   = key_valid ? 4'(key_arr[idx]) : 4'($urandom);
      acc       = key_valid && key_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    key_valid = 1'b0;
    chk("load_done", idx, KL);
  endtask

  task automatic wait_valid(output int e);
    e = 0;
    while (!ks_valid && e < 300) begin
      @(posedge clk); #1;
      e++;
    end
    chk("ks_valid_rise", int'(ks_valid), 1);
  endtask

  task automatic stream_check(input string tag, input int n);
    ks_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk(tag, int'({ks_valid, ks_word}), 16 + model_next());
      @(posedge clk); #1;
    end
  endtask

  task automatic do_rekey();
    rekey     = 1'b1;
    key_valid = 1'b1;
    key_nib   = 4'($urandom);
    ks_ready  = 1'b1;
    @(posedge clk); #1;
    rekey     = 1'b0;
    key_valid = 1'b0;
    chk("rekey_ks_valid", int'(ks_valid), 0);
    chk("rekey_key_ready", int'(key_ready), 0);
    chk("rekey_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("idle_key_ready", int'(key_ready), 0);
  endtask

  initial begin
    int e, got, cyc, mask;
    bit v;
    int w;
    rekey = 1'b0; key_valid = 1'b0; key_nib = 4'h0; ks_ready = 1'b1;

    #1 reset = 1'b0;
    #2;
    chk("rst_key_ready", int'(key_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ks_valid", int'(ks_valid), 0);
    chk("rst_ks_word", int'(ks_word), 0);
    #15 reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_key_ready_e1", int'(key_ready), 0);
    @(posedge clk); #1;
    chk("rel_key_ready_e2", int'(key_ready), 1);

    // Key 0x0123456789ABCDEF, nibbles sent MS first: 0..F, gap-free.
    for (int k = 0; k < KL; k++) key_arr[k] = k;
    model_ksa();
    load_key(0);
    chk("key_ready_after_load", int'(key_ready), 0);
    chk("busy_after_load", int'(busy), 1);
    wait_valid(e);
    chk("latency", e, LAT);
    stream_check("gen_word", 64);
    mask = 0;
    for (int k = 0; k < N; k++) mask |= (1 << dut.s_q[k]);
    chk("s_perm", mask, 32'hFFFF);

    // Same key, random backpressure.
    do_rekey();
    model_ksa();
    load_key(0);
    wait_valid(e);
    got = 0;
    cyc = 0;
    while (got < 64 && cyc < 2000) begin
      ks_ready = 1'($urandom_range(0, 1));
      v = ks_valid;
      w = int'(ks_word);
      @(posedge clk); #1;
      cyc++;
      if (v && ks_ready) begin
        chk("rand_word", w, model_next());
        got++;
      end else if (v) begin
        chk("hold_word", int'({ks_valid, ks_word}), 16 + w);
      end
    end
    chk("rand_count", got, 64);
    ks_ready = 1'b1;

    // Gapped key load, every third cycle.
    do_rekey();
    model_ksa();
    load_key(3);
    wait_valid(e);
    stream_check("gap_word", 16);

    // Rekey while streaming with key_valid asserted; fresh random key.
    do_rekey();
    for (int k = 0; k < KL; k++) key_arr[k] = int'($urandom_range(0, 15));
    model_ksa();
    load_key(0);
    wait_valid(e);
    stream_check("newkey_word", 32);

    // Asynchronous reset in the middle of KSA.
    do_rekey();
    load_key(0);
    repeat (5) begin @(posedge clk); #1; end
    chk("busy_mid_ksa", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_key_ready", int'(key_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ks_valid", int'(ks_valid), 0);
    chk("midrst_ks_word", int'(ks_word), 0);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rel_e1", int'(key_ready), 0);
    @(posedge clk); #1;
    chk("midrst_rel_e2", int'(key_ready), 1);
    for (int k = 0; k < KL; k++) key_arr[k] = 15 - k;
    model_ksa();
    load_key(0);
    wait_valid(e);
    chk("latency_after_rst", e, LAT);
    stream_check("rst_word", 8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
